// File: rtl/bluetooth_tx.sv
// -----------------------------------------------------------------------------
// bluetooth_tx
//   UART transmitter for the HC-05 Bluetooth link. Bytes from game logic are
//   taken over a valid/ready handshake and queued in a small circular FIFO.
//   Each byte is sent as an 8N1 frame (start 0, eight data bits LSB first,
//   stop 1). Each bit lasts CLKS_PER_BIT = CLK_FREQ / BAUD clocks.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   tx_data     in   byte to send
//   tx_valid    in   tx_data valid this cycle
//   tx_ready    out  FIFO can accept a byte (not full)
//   tx          out  registered serial line, idle high
//   busy        out  frame in progress or bytes still queued
//   frame_done  out  one-cycle pulse on the last clock of each stop bit
// -----------------------------------------------------------------------------
module bluetooth_tx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CNT_W        = PTR_W + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // ---------------------------------------------------------------- FIFO
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic       w_push;
    logic       w_pop;
    logic       w_empty;
    logic       w_full;
    logic [7:0] w_head;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CNT_FULL);
    assign tx_ready = !w_full;
    assign w_push   = tx_valid && !w_full;
    assign w_head   = r_mem[r_rd_ptr];

    // NOTE: the storage array has no reset; only pointers and count decide
    // which entries are meaningful, so clearing the data would be wasted logic.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;  // idle, or push and pop together
            endcase
        end
    end

    // ---------------------------------------------------------------- FSM
    state_t            r_state;
    state_t            w_state_next;
    logic [BAUD_W-1:0] r_baud;
    logic [BAUD_W-1:0] w_baud_next;
    logic [2:0]        r_bit_idx;
    logic [2:0]        w_bit_idx_next;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_next;
    logic              r_tx;
    logic              w_tx_next;
    logic              w_bit_end;

    assign w_bit_end = (r_baud == BAUD_LAST);

    // NOTE: every signal driven here gets a default before the case so no
    // path leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next   = r_state;
        w_baud_next    = w_bit_end ? '0 : r_baud + BAUD_W'(1);
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_pop          = 1'b0;
        w_tx_next      = 1'b1;

        case (r_state)
            S_IDLE: begin
                w_baud_next = '0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_bit_idx_next = 3'd0;
                    w_state_next   = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_next   = {1'b0, r_shift[7:1]};
                    w_bit_idx_next = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    // Chain straight into the next start bit when a byte is
                    // waiting, so back-to-back frames have no idle gap.
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_head;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
        endcase

        // The line level is decoded from the next state so the tx flop
        // changes on the same edge as the state it belongs to.
        case (w_state_next)
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
        end
    end

    assign tx         = r_tx;
    assign busy       = (r_state != S_IDLE) || !w_empty;
    assign frame_done = (r_state == S_STOP) && w_bit_end;

endmodule

// File: tb/tb_bluetooth_tx.sv
// -----------------------------------------------------------------------------
// tb_bluetooth_tx
//   Self-checking bench for bluetooth_tx. The main instance runs at 16 clocks
//   per bit. A second instance checks divisor truncation: 100_000 / 9600 gives
//   10 clocks per bit.
//   The reference model works from a list of (accept edge, byte) pairs. It
//   derives each frame's start as max(accept + 1, previous frame end) and
//   computes the expected line level, frame_done and busy for any cycle.
//   Cycle t means the sample taken 1 time unit after relative clock edge t.
// -----------------------------------------------------------------------------
module tb_bluetooth_tx;

    localparam int CPB   = 16;
    localparam int FRAME = 10 * CPB;
    localparam int CPB2  = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       busy;
    logic       frame_done;

    logic [7:0] d2_data;
    logic       d2_valid;
    logic       d2_ready;
    logic       d2_tx;
    logic       d2_busy;
    logic       d2_done;

    int checks   = 0;
    int failures = 0;

    int         m_acc[$];
    int         m_from[$];
    logic [7:0] m_byte[$];
    int         m_start[$];

    always #5 clk = ~clk;

    bluetooth_tx #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(4)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    bluetooth_tx #(.CLK_FREQ(100_000), .BAUD(9600), .FIFO_DEPTH(4)) u_dut_div (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (d2_data),
        .tx_valid   (d2_valid),
        .tx_ready   (d2_ready),
        .tx         (d2_tx),
        .busy       (d2_busy),
        .frame_done (d2_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------ model
    function automatic void model_clear();
        m_acc.delete();
        m_from.delete();
        m_byte.delete();
        m_start.delete();
    endfunction

    // acc: edge at which the byte is expected to be accepted;
    // from: first edge at which tx_valid is raised for it.
    function automatic void model_add(int acc, int from, logic [7:0] b);
        m_acc.push_back(acc);
        m_from.push_back(from);
        m_byte.push_back(b);
    endfunction

    function automatic void model_schedule();
        int prev_end;
        int s;
        prev_end = 0;
        m_start.delete();
        for (int j = 0; j < m_acc.size(); j++) begin
            s = (m_acc[j] + 1 > prev_end) ? m_acc[j] + 1 : prev_end;
            m_start.push_back(s);
            prev_end = s + FRAME;
        end
    endfunction

    function automatic int model_end();
        return m_start[m_start.size() - 1] + FRAME;
    endfunction

    function automatic logic model_tx(int t);
        int         k;
        logic [7:0] b;
        for (int j = 0; j < m_start.size(); j++) begin
            if (t >= m_start[j] && t < m_start[j] + FRAME) begin
                k = (t - m_start[j]) / CPB;
                b = m_byte[j];
                if (k == 0) return 1'b0;
                if (k == 9) return 1'b1;
                return b[k-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic model_fd(int t);
        for (int j = 0; j < m_start.size(); j++) begin
            if (t == m_start[j] + FRAME - 1) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic model_busy(int t);
        for (int j = 0; j < m_start.size(); j++) begin
            if (m_acc[j] <= t && t < m_start[j] + FRAME) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Drives the inputs for the coming edge t from the plan. v tells whether
    // tx_valid is raised; er is the tx_ready the plan expects at that edge.
    task automatic plan_drive(input int t, output logic v, output logic er);
        v        = 1'b0;
        er       = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        for (int j = 0; j < m_acc.size(); j++) begin
            if (t >= m_from[j] && t <= m_acc[j]) begin
                tx_valid = 1'b1;
                tx_data  = m_byte[j];
                v        = 1'b1;
                er       = (t == m_acc[j]);
                break;
            end
        end
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({tx, tx_ready, busy, frame_done} !== 4'b1100) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got={tx,rdy,busy,fd}=%b exp=1100", i, {tx, tx_ready, busy, frame_done});
            end
        end
        reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if ({tx, tx_ready, busy, frame_done, d2_tx, d2_busy} !== 6'b110010) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=110010", i, {tx, tx_ready, busy, frame_done, d2_tx, d2_busy});
            end
        end
    endtask

    task automatic test_single_byte();
        logic v, er;
        model_clear();
        model_add(1, 1, 8'hA5);
        model_schedule();
        for (int t = 1; t <= model_end() + 2; t++) begin
            plan_drive(t, v, er);
            if (v) begin
                checks++;
                if (tx_ready !== er) begin
                    failures++;
                    $display("FAIL single_ready t=%0d got=%b exp=%b", t, tx_ready, er);
                end
            end
            tick();
            checks++;
            if ({tx, frame_done, busy} !== {model_tx(t), model_fd(t), model_busy(t)}) begin
                failures++;
                $display("FAIL single t=%0d got={tx,fd,busy}=%b exp=%b", t, {tx, frame_done, busy}, {model_tx(t), model_fd(t), model_busy(t)});
            end
        end
    endtask

    // With tx_valid held from edge 1: edges 1..5 accept 0x01..0x05 (the first
    // goes to the shifter at edge 2, four stay queued). The second pop happens
    // when the first frame ends (edge 162), so 0x06 is accepted at edge 163.
    task automatic test_burst();
        logic v, er;
        model_clear();
        for (int j = 0; j < 5; j++) model_add(j + 1, 1, 8'(j + 1));
        model_add(163, 1, 8'h06);
        model_schedule();
        for (int t = 1; t <= model_end() + 2; t++) begin
            plan_drive(t, v, er);
            if (v) begin
                checks++;
                if (tx_ready !== er) begin
                    failures++;
                    $display("FAIL burst_ready t=%0d got=%b exp=%b", t, tx_ready, er);
                end
            end
            tick();
            checks++;
            if ({tx, frame_done, busy} !== {model_tx(t), model_fd(t), model_busy(t)}) begin
                failures++;
                $display("FAIL burst t=%0d got={tx,fd,busy}=%b exp=%b", t, {tx, frame_done, busy}, {model_tx(t), model_fd(t), model_busy(t)});
            end
        end
    endtask

    task automatic test_edge_patterns();
        logic v, er;
        int   low0, low1, fd_n;
        low0 = 0;
        low1 = 0;
        fd_n = 0;
        model_clear();
        model_add(1, 1, 8'h00);
        model_add(2, 2, 8'hFF);
        model_schedule();
        for (int t = 1; t <= model_end() + 2; t++) begin
            plan_drive(t, v, er);
            if (v) begin
                checks++;
                if (tx_ready !== er) begin
                    failures++;
                    $display("FAIL edge_ready t=%0d got=%b exp=%b", t, tx_ready, er);
                end
            end
            tick();
            if (tx === 1'b0 && t < m_start[1]) low0++;
            else if (tx === 1'b0) low1++;
            if (frame_done === 1'b1) fd_n++;
            checks++;
            if ({tx, frame_done, busy} !== {model_tx(t), model_fd(t), model_busy(t)}) begin
                failures++;
                $display("FAIL edge t=%0d got={tx,fd,busy}=%b exp=%b", t, {tx, frame_done, busy}, {model_tx(t), model_fd(t), model_busy(t)});
            end
        end
        checks++;
        if (low0 !== 9 * CPB) begin
            failures++;
            $display("FAIL edge_low_00 got=%0d exp=%0d", low0, 9 * CPB);
        end
        checks++;
        if (low1 !== CPB) begin
            failures++;
            $display("FAIL edge_low_ff got=%0d exp=%0d", low1, CPB);
        end
        checks++;
        if (fd_n !== 2) begin
            failures++;
            $display("FAIL edge_frame_done_count got=%0d exp=2", fd_n);
        end
    endtask

    // Random bytes with random gaps. At most five bytes are ever in flight, so
    // the FIFO never fills and every offer must be accepted immediately.
    task automatic test_random();
        logic v, er;
        int   a;
        for (int r = 0; r < 3; r++) begin
            model_clear();
            a = 1 + int'($urandom_range(0, 3));
            for (int j = 0; j < 5; j++) begin
                model_add(a, a, 8'($urandom));
                a = a + 1 + int'($urandom_range(0, 200));
            end
            model_schedule();
            for (int t = 1; t <= model_end() + 2; t++) begin
                plan_drive(t, v, er);
                if (v) begin
                    checks++;
                    if (tx_ready !== er) begin
                        failures++;
                        $display("FAIL random_ready r=%0d t=%0d got=%b exp=%b", r, t, tx_ready, er);
                    end
                end
                tick();
                checks++;
                if ({tx, frame_done, busy} !== {model_tx(t), model_fd(t), model_busy(t)}) begin
                    failures++;
                    $display("FAIL random r=%0d t=%0d got={tx,fd,busy}=%b exp=%b", r, t, {tx, frame_done, busy}, {model_tx(t), model_fd(t), model_busy(t)});
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic v, er;
        int   bad;
        model_clear();
        for (int j = 0; j < 3; j++) model_add(j + 1, j + 1, 8'($urandom));
        model_schedule();
        // Frame 0 starts at cycle 2; data bit 3 spans cycles 66..81.
        for (int t = 1; t <= 71; t++) begin
            plan_drive(t, v, er);
            tick();
            checks++;
            if ({tx, frame_done, busy} !== {model_tx(t), model_fd(t), model_busy(t)}) begin
                failures++;
                $display("FAIL midrst_pre t=%0d got={tx,fd,busy}=%b exp=%b", t, {tx, frame_done, busy}, {model_tx(t), model_fd(t), model_busy(t)});
            end
        end
        tx_valid = 1'b0;
        model_clear();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({tx, tx_ready, busy, frame_done} !== 4'b1100) begin
            failures++;
            $display("FAIL midrst_async got={tx,rdy,busy,fd}=%b exp=1100", {tx, tx_ready, busy, frame_done});
        end
        tick();
        tick();
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if ({tx, frame_done, busy} !== 3'b100) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL midrst_after bad_cycles=%0d exp=0", bad);
        end
    endtask

    task automatic test_divisor();
        int   edges[$];
        logic prev;
        int   fd_n, fd_t;
        fd_n = 0;
        fd_t = -1;
        d2_valid = 1'b1;
        d2_data  = 8'h55;
        tick();
        d2_valid = 1'b0;
        prev = 1'b1;
        checks++;
        if (d2_tx !== 1'b1) begin
            failures++;
            $display("FAIL div_accept_edge got=%b exp=1", d2_tx);
        end
        for (int t = 2; t <= 2 + 10 * CPB2 + 5; t++) begin
            tick();
            if (d2_tx !== prev) edges.push_back(t);
            prev = d2_tx;
            if (d2_done === 1'b1) begin
                fd_n++;
                fd_t = t;
            end
            if (t == 2 + 10 * CPB2 - 1 || t == 2 + 10 * CPB2) begin
                checks++;
                if (d2_busy !== (t == 2 + 10 * CPB2 - 1)) begin
                    failures++;
                    $display("FAIL div_busy t=%0d got=%b", t, d2_busy);
                end
            end
        end
        // 0x55 toggles the line at every bit boundary: 10 transitions.
        checks++;
        if (edges.size() !== 10) begin
            failures++;
            $display("FAIL div_edges got=%0d exp=10", edges.size());
        end
        for (int k = 0; k < edges.size() && k < 10; k++) begin
            checks++;
            if (edges[k] !== 2 + k * CPB2) begin
                failures++;
                $display("FAIL div_edge_time k=%0d got=%0d exp=%0d", k, edges[k], 2 + k * CPB2);
            end
        end
        checks++;
        if (fd_n !== 1 || fd_t !== 2 + 10 * CPB2 - 1) begin
            failures++;
            $display("FAIL div_frame_done n=%0d t=%0d exp n=1 t=%0d", fd_n, fd_t, 2 + 10 * CPB2 - 1);
        end
    endtask

    initial begin
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        d2_valid = 1'b0;
        d2_data  = 8'h00;
        #3;
        reset = 1'b0;
        test_reset();
        test_single_byte();
        test_burst();
        test_edge_patterns();
        test_random();
        test_reset_mid_frame();
        test_divisor();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bluetooth_tx.md
# bluetooth_tx

UART transmitter for the HC-05 Bluetooth link. It is the outbound counterpart of the existing `bluetooth` receiver. Game logic hands it bytes, such as score or game-over reports, over a valid/ready handshake. The block buffers them in a small FIFO and serialises each byte as an 8N1 frame on the module's TX pin. It sits in `top` beside `bluetooth` and shares `clk` and `reset`.

## Interface
Parameters:
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate.
  - `CLKS_PER_BIT = CLK_FREQ / BAUD`, integer truncation: 10416 at the defaults.
  - Must be ≥ 2.
- `FIFO_DEPTH`, default 4: byte buffer depth. Power of two, ≥ 2.

Ports:
- `clk`  in  1: system clock. All logic on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `tx_data`  in  8: byte to send.
- `tx_valid`  in  1: `tx_data` is valid this cycle.
- `tx_ready`  out  1: the FIFO can accept a byte (FIFO not full).
- `tx`  out  1: serial line to the module RXD. Idle high.
- `busy`  out  1: FSM not in IDLE, or FIFO not empty.
- `frame_done`  out  1: one-cycle pulse when a stop bit completes.

## Operation
- **Handshake:** a byte is accepted on the rising edge where `tx_valid && tx_ready` is high.
  - `tx_valid` while `tx_ready` is low has no effect.
  - Data is not required to be held after acceptance.
- **FIFO:** circular buffer with `FIFO_DEPTH` entries and a count of width log2(`FIFO_DEPTH`)+1.
  - A push and a pop in the same cycle are legal and leave the count unchanged.
  - A pop never occurs when the FIFO is empty.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is non-empty. On that edge the head is popped into the shift register and the baud counter is cleared.
  - START drives `tx = 0` for `CLKS_PER_BIT` cycles, then → DATA with bit index 0.
  - DATA drives `tx = shift[0]` (LSB first) for `CLKS_PER_BIT` cycles per bit.
    - After each bit: shift right and increment the index.
    - After bit index 7 → STOP.
  - STOP drives `tx = 1` for `CLKS_PER_BIT` cycles. On its last cycle, `frame_done` pulses for one cycle, then:
    - if the FIFO is non-empty, pop and go directly to START, with no idle gap;
    - otherwise → IDLE.
- **Output registering:** `tx` is registered and glitch-free.
- **Baud counter:** counts 0..`CLKS_PER_BIT`−1, wraps to 0 at each bit boundary, and is held at 0 in IDLE.

## Timing
- **Reset values:**
  - `tx` = 1
  - `tx_ready` = 1
  - `busy` = 0
  - `frame_done` = 0
  - FIFO empty, FSM in IDLE, counters 0.
- **Reset during operation:** asserting `reset` mid-frame forces the reset values immediately (asynchronously). Queued bytes are discarded. No partial frame resumes after release.
- **Latency:** with the FIFO empty and the FSM idle, a byte accepted at edge N causes the FSM to pop at edge N+1. `tx` is low from edge N+1.
- **Frame length:** exactly 10 × `CLKS_PER_BIT` cycles. The start-bit falling edge of a back-to-back frame coincides with the end of the previous stop bit.
- **`tx_ready` timing:** `tx_ready` = !full and is combinational from the count.
  - With continuous `tx_valid` from idle, `FIFO_DEPTH` + 1 bytes are accepted before `tx_ready` falls: one goes into the shifter, `FIFO_DEPTH` stay queued.
  - `tx_ready` rises the cycle after each pop.
- **`busy` timing:** `busy` falls the edge after the final `frame_done`.

## Test plan
1. **Reset values.** Assert `reset` = 0 for 3 cycles, then release.
   - Required: `tx` = 1, `tx_ready` = 1, `busy` = 0, `frame_done` = 0 throughout. No activity for 100 cycles with `tx_valid` = 0.
2. **Single byte.** Use `CLK_FREQ` = 16, `BAUD` = 1 (16 cycles per bit). Send 0xA5 at edge N.
   - `tx` = 0 over edges N+1..N+16.
   - Data bits, LSB first: 1,0,1,0,0,1,0,1, each 16 cycles.
   - Stop bit high, with `frame_done` pulsing on cycle N+160.
   - `busy` = 0 from N+161.
3. **Burst.** Same parameters. Hold `tx_valid` with bytes 0x01..0x06.
   - 0x01..0x05 are accepted, then `tx_ready` = 0.
   - 0x06 is accepted one cycle after the first queued pop.
   - Six contiguous frames of 160 cycles each, with no high gap between stop and start, decoded as 0x01..0x06.
4. **Edge patterns.** Send 0x00, then 0xFF.
   - First frame: low for 9 bit-times, then the stop bit.
   - Second frame: a single low start bit, then 9 high bit-times.
   - Exactly two `frame_done` pulses.
5. **Reset mid-frame.** Pull `reset` low during data bit 3 of the first of 3 queued bytes.
   - `tx` = 1 and `busy` = 0 within the same cycle.
   - After release: `tx` stays 1 for 1000 cycles and no `frame_done` occurs.
6. **Default divisor.** Use default parameters and send 0x55.
   - Every bit period measures exactly 10416 clocks.
   - Total frame is 104160 clocks.
